mem_arbiter: RTL and testbench

- Two-port to one-port line arbiter. It lets the instruction-side and data-side L2 caches share a single slow_memory instance.
- Sits directly downstream of both cache_L2 instances and directly upstream of slow_memory.
- Uses the same 128-bit line handshake on all three ports: the requester holds read or write until ready, and ready pulses with read data valid.
- Round-robin grant on contention; one outstanding transaction at a time; per-port transfer counters for performance checks.

---
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: lets the I-side and D-side L2 caches share one slow_memory port.
//   i_*/d_*   : requester line ports (hold read/write until a one-cycle ready pulse)
//   mem_*     : single line port towards slow_memory
//   *_xfer_cnt: wrapping count of completed transactions per requester
module mem_arbiter #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned LINE_W = 128,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  i_xfer_cnt,
  output logic [CNT_W-1:0]  d_xfer_cnt
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;
  typedef enum logic {GNT_I, GNT_D} grant_t;

  state_t state, state_nxt;
  grant_t last_grant, last_grant_nxt;
  logic   req_i, req_d;
  logic   take_i, take_d;
  logic   done_i, done_d;

  assign req_i = i_read | i_write;
  assign req_d = d_read | d_write;

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state      <= IDLE;
      last_grant <= GNT_I;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    take_i         = 1'b0;
    take_d         = 1'b0;
    done_i         = 1'b0;
    done_d         = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_i && req_d) begin
          if (last_grant == GNT_I) take_d = 1'b1;
          else                     take_i = 1'b1;
        end else if (req_i) begin
          take_i = 1'b1;
        end else if (req_d) begin
          take_d = 1'b1;
        end
        if (take_i) begin
          state_nxt      = BUSY_I;
          last_grant_nxt = GNT_I;
        end else if (take_d) begin
          state_nxt      = BUSY_D;
          last_grant_nxt = GNT_D;
        end
      end
      BUSY_I: begin
        if (mem_ready) begin
          done_i    = 1'b1;
          state_nxt = DONE;
        end
      end
      BUSY_D: begin
        if (mem_ready) begin
          done_d    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_ready    <= 1'b0;
      d_ready    <= 1'b0;
      i_xfer_cnt <= '0;
      d_xfer_cnt <= '0;
    end else begin
      // ready is high only in DONE, which always lasts one cycle
      i_ready <= done_i;
      d_ready <= done_d;
      // write wins when a requester raises both read and write
      if (take_i) begin
        mem_write <= i_write;
        mem_read  <= i_read & ~i_write;
        mem_addr  <= i_addr;
        mem_wdata <= i_wdata;
      end else if (take_d) begin
        mem_write <= d_write;
        mem_read  <= d_read & ~d_write;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else if (done_i || done_d) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
      end
      if (done_i) begin
        if (mem_read) i_rdata <= mem_rdata;
        i_xfer_cnt <= i_xfer_cnt + CNT_W'(1);
      end
      if (done_d) begin
        if (mem_read) d_rdata <= mem_rdata;
        d_xfer_cnt <= d_xfer_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int unsigned AW  = 28;
  localparam int unsigned LW  = 128;
  localparam int unsigned CW  = 16;
  localparam int unsigned LAT = 4;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } mem_op_t;

  logic          clk;
  logic          proc_reset;
  logic          i_read, i_write, d_read, d_write;
  logic [AW-1:0] i_addr, d_addr;
  logic [LW-1:0] i_wdata, d_wdata;
  logic [LW-1:0] i_rdata, d_rdata;
  logic          i_ready, d_ready;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata, mem_rdata;
  logic          mem_ready;
  logic [CW-1:0] i_xfer_cnt, d_xfer_cnt;

  // second instance with 2-bit counters, fed the same stimulus, to see the wrap
  logic [LW-1:0] s_i_rdata, s_d_rdata, s_mem_wdata;
  logic          s_i_ready, s_d_ready, s_mem_read, s_mem_write;
  logic [AW-1:0] s_mem_addr;
  logic [1:0]    s_i_cnt, s_d_cnt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;
  int unsigned rise_cyc = 0;
  int unsigned rdy_cyc = 0;
  int unsigned req_cyc_i = 0;

  mem_op_t       exp_mem[$];
  logic [LW-1:0] exp_i[$];
  logic [LW-1:0] exp_d[$];
  logic [CW-1:0] model_i = '0;
  logic [CW-1:0] model_d = '0;
  logic [LW-1:0] model_i_rdata = '0;
  logic [LW-1:0] model_d_rdata = '0;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .CNT_W(CW)) dut (
    .clk(clk), .proc_reset(proc_reset),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .i_xfer_cnt(i_xfer_cnt), .d_xfer_cnt(d_xfer_cnt)
  );

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .CNT_W(2)) dut_w2 (
    .clk(clk), .proc_reset(proc_reset),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(s_i_rdata), .i_ready(s_i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(s_d_rdata), .d_ready(s_d_ready),
    .mem_read(s_mem_read), .mem_write(s_mem_write), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .i_xfer_cnt(s_i_cnt), .d_xfer_cnt(s_d_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] mem_line(input logic [AW-1:0] a);
    return {4{32'hA5A5A5A5}} ^ LW'(a);
  endfunction

  function automatic mem_op_t mk_op(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] wd);
    mem_op_t o;
    o.wr = wr;
    o.addr = a;
    o.wdata = wd;
    return o;
  endfunction

  // slow_memory model: checks each new request against the scoreboard, answers LAT cycles later
  initial begin
    int unsigned cnt;
    logic [AW-1:0] acc_addr;
    mem_op_t e;
    cnt = 0;
    acc_addr = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (cnt > 0) begin
        if ((mem_read || mem_write) && !proc_reset)
          check("mem_addr_stable", LW'(mem_addr), LW'(acc_addr));
        cnt--;
        if (cnt == 0) begin
          mem_ready = 1'b1;
          mem_rdata = mem_line(acc_addr);
          rdy_cyc = cyc;
        end
      end else if ((mem_read || mem_write) && !proc_reset) begin
        acc_addr = mem_addr;
        rise_cyc = cyc;
        cnt = LAT;
        check("shadow_addr", LW'(s_mem_addr), LW'(mem_addr));
        if (exp_mem.size() == 0) begin
          check("mem_unexpected_req", 1, 0);
        end else begin
          e = exp_mem.pop_front();
          check("mem_op", LW'({mem_write, mem_read}), LW'({e.wr, !e.wr}));
          check("mem_addr", LW'(mem_addr), LW'(e.addr));
          if (e.wr) check("mem_wdata", mem_wdata, e.wdata);
        end
      end
    end
  end

  // completion monitor for both requesters
  initial begin
    logic prev_i, prev_d;
    prev_i = 1'b0;
    prev_d = 1'b0;
    forever begin
      @(negedge clk);
      if (!proc_reset) begin
        if (i_ready) begin
          check("i_ready_lat", cyc, rdy_cyc + 1);
          check("i_ready_pulse", LW'(prev_i), 0);
          if (exp_i.size() == 0) check("i_unexpected_ready", 1, 0);
          else check("i_rdata", i_rdata, exp_i.pop_front());
          model_i++;
          check("i_xfer_cnt", LW'(i_xfer_cnt), LW'(model_i));
          check("i_xfer_cnt_w2", LW'(s_i_cnt), LW'(model_i[1:0]));
        end
        if (d_ready) begin
          check("d_ready_lat", cyc, rdy_cyc + 1);
          check("d_ready_pulse", LW'(prev_d), 0);
          if (exp_d.size() == 0) check("d_unexpected_ready", 1, 0);
          else check("d_rdata", d_rdata, exp_d.pop_front());
          model_d++;
          check("d_xfer_cnt", LW'(d_xfer_cnt), LW'(model_d));
          check("d_xfer_cnt_w2", LW'(s_d_cnt), LW'(model_d[1:0]));
        end
      end
      prev_i = i_ready;
      prev_d = d_ready;
    end
  end

  // call at a falling edge; returns at a falling edge
  task automatic xact(input bit d_side, input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] wd);
    int unsigned n;
    n = 0;
    if (!d_side) begin
      if (!wr) model_i_rdata = mem_line(a);
      exp_i.push_back(model_i_rdata);
      i_addr = a; i_wdata = wd; i_write = wr; i_read = !wr;
      req_cyc_i = cyc;
      while (!i_ready && n < 60) begin
        @(negedge clk);
        n++;
      end
      if (!i_ready) check("i_timeout", 0, 1);
      i_read = 1'b0; i_write = 1'b0;
    end else begin
      if (!wr) model_d_rdata = mem_line(a);
      exp_d.push_back(model_d_rdata);
      d_addr = a; d_wdata = wd; d_write = wr; d_read = !wr;
      while (!d_ready && n < 60) begin
        @(negedge clk);
        n++;
      end
      if (!d_ready) check("d_timeout", 0, 1);
      d_read = 1'b0; d_write = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    proc_reset = 1'b1;
    i_read = 1'b0; i_write = 1'b0; d_read = 1'b0; d_write = 1'b0;
    @(negedge clk);
    model_i = '0; model_d = '0;
    model_i_rdata = '0; model_d_rdata = '0;
    check("rst_mem_read", LW'(mem_read), 0);
    check("rst_mem_write", LW'(mem_write), 0);
    check("rst_mem_addr", LW'(mem_addr), 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_i_ready", LW'(i_ready), 0);
    check("rst_d_ready", LW'(d_ready), 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_i_cnt", LW'(i_xfer_cnt), 0);
    check("rst_d_cnt", LW'(d_xfer_cnt), 0);
    proc_reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [LW-1:0] wd;
    int unsigned n;
    proc_reset = 1'b1;
    i_read = 1'b0; i_write = 1'b0; i_addr = '0; i_wdata = '0;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
    @(negedge clk);
    do_reset();

    // 1: lone I read
    exp_mem.push_back(mk_op(1'b0, 28'h0000010, '0));
    xact(1'b0, 1'b0, 28'h0000010, '0);
    check("t1_arb_latency", rise_cyc - req_cyc_i, 1);
    check("t1_i_cnt", LW'(i_xfer_cnt), 1);
    check("t1_d_cnt", LW'(d_xfer_cnt), 0);

    // 2: simultaneous first requests after reset, D wins the tie
    do_reset();
    exp_mem.push_back(mk_op(1'b0, 28'h40, '0));
    exp_mem.push_back(mk_op(1'b0, 28'h10, '0));
    fork
      xact(1'b1, 1'b0, 28'h40, '0);
      xact(1'b0, 1'b0, 28'h10, '0);
    join
    check("t2_i_cnt", LW'(i_xfer_cnt), 1);
    check("t2_d_cnt", LW'(d_xfer_cnt), 1);

    // 3: continuous contention alternates D, I, D, I, D, I
    for (int k = 0; k < 3; k++) begin
      exp_mem.push_back(mk_op(1'b0, AW'(32'h200 + k), '0));
      exp_mem.push_back(mk_op(1'b0, AW'(32'h300 + k), '0));
    end
    fork
      begin
        for (int k = 0; k < 3; k++) xact(1'b1, 1'b0, AW'(32'h200 + k), '0);
      end
      begin
        for (int k = 0; k < 3; k++) xact(1'b0, 1'b0, AW'(32'h300 + k), '0);
      end
    join
    check("t3_i_cnt", LW'(i_xfer_cnt), 4);
    check("t3_d_cnt", LW'(d_xfer_cnt), 4);

    // 4: D write leaves d_rdata alone
    wd = {64'h0123_4567_89AB_CDEF, 64'h0000_0000_0000_0D5D};
    exp_mem.push_back(mk_op(1'b1, 28'h10, wd));
    xact(1'b1, 1'b1, 28'h10, wd);
    check("t4_d_rdata_hold", d_rdata, mem_line(28'h202));
    check("t4_d_cnt", LW'(d_xfer_cnt), 5);

    // 5: reset while BUSY_I, memory completion arrives afterwards
    exp_mem.push_back(mk_op(1'b0, 28'h77, '0));
    i_addr = 28'h77; i_read = 1'b1;
    n = 0;
    while (!mem_read && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t5_busy", LW'(mem_read), 1);
    @(negedge clk);
    do_reset();
    repeat (8) @(negedge clk);
    check("t5_i_cnt", LW'(i_xfer_cnt), 0);
    check("t5_d_cnt", LW'(d_xfer_cnt), 0);
    check("t5_i_rdata", i_rdata, 0);

    // 6: counter wrap, seen on the 2-bit instance
    exp_mem.push_back(mk_op(1'b0, 28'h50, '0));
    xact(1'b1, 1'b0, 28'h50, '0);
    for (int k = 0; k < 4; k++) begin
      exp_mem.push_back(mk_op(1'b0, AW'(32'h100 + k), '0));
      xact(1'b0, 1'b0, AW'(32'h100 + k), '0);
    end
    check("t6_w2_i_wrapped", LW'(s_i_cnt), 0);
    check("t6_w2_d_kept", LW'(s_d_cnt), 1);
    check("t6_i_cnt", LW'(i_xfer_cnt), 4);
    check("t6_d_cnt", LW'(d_xfer_cnt), 1);

    repeat (4) @(negedge clk);
    check("exp_mem_drained", exp_mem.size(), 0);
    check("exp_i_drained", exp_i.size(), 0);
    check("exp_d_drained", exp_d.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
